// File: rtl/multi_clk_divider_if.sv
// Configuration and output bundle for the multi-channel clock divider.
// The master side drives enables and divisor writes; the slave is the divider.
interface multi_clk_divider_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] en;
    logic                div_wr;
    logic [CH_W-1:0]     div_ch;
    logic [CNT_W-1:0]    div_val;
    logic [CHANNELS-1:0] clk_div;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;

    modport master (
        output en, div_wr, div_ch, div_val,
        input  clk_div, tick, pending
    );

    modport slave (
        input  en, div_wr, div_ch, div_val,
        output clk_div, tick, pending
    );
endinterface

// File: rtl/multi_clk_divider.sv
// Runtime-programmable multi-channel divider producing a divided-clock level and
// a period tick per channel; divisor changes are deferred to period boundaries.
module multi_clk_divider #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    multi_clk_divider_if.slave cfg
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0]    cnt_q      [CHANNELS];
    logic [CNT_W-1:0]    cur_div_q  [CHANNELS];
    logic [CNT_W-1:0]    pend_div_q [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] clk_div_q;
    logic [CHANNELS-1:0] tick_q;

    logic [CNT_W-1:0]    cnt_nx      [CHANNELS];
    logic [CNT_W-1:0]    cur_div_nx  [CHANNELS];
    logic [CNT_W-1:0]    pend_div_nx [CHANNELS];
    logic [CHANNELS-1:0] pending_nx;
    logic [CHANNELS-1:0] clk_div_nx;
    logic [CHANNELS-1:0] tick_nx;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] bnd;
    logic [CHANNELS-1:0] hit;
    logic [CNT_W-1:0]    wr_val;

    assign wr_val = (cfg.div_val < TWO) ? TWO : cfg.div_val;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nx[i]      = cnt_q[i];
            cur_div_nx[i]  = cur_div_q[i];
            pend_div_nx[i] = pend_div_q[i];
            pending_nx[i]  = pending_q[i];
            clk_div_nx[i]  = 1'b0;
            tick_nx[i]     = 1'b0;
            wrap[i]        = 1'b0;
            bnd[i]         = 1'b0;
            hit[i]         = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            // Out-of-range channel indices never match any i, so they are dropped.
            hit[i]  = cfg.div_wr && (cfg.div_ch == CH_W'(i));
            wrap[i] = (cnt_q[i] == cur_div_q[i] - ONE);
            bnd[i]  = !cfg.en[i] || wrap[i];

            if (bnd[i]) begin
                // A write landing on the boundary itself bypasses the pending stage.
                if (hit[i]) begin
                    cur_div_nx[i]  = wr_val;
                    pend_div_nx[i] = wr_val;
                end else if (pending_q[i]) begin
                    cur_div_nx[i] = pend_div_q[i];
                end
                pending_nx[i] = 1'b0;
                cnt_nx[i]     = '0;
            end else begin
                if (hit[i]) begin
                    pend_div_nx[i] = wr_val;
                    pending_nx[i]  = 1'b1;
                end
                cnt_nx[i] = cnt_q[i] + ONE;
            end

            if (cfg.en[i]) begin
                clk_div_nx[i] = (cnt_nx[i] >= (cur_div_nx[i] >> 1));
                tick_nx[i]    = (cnt_nx[i] == cur_div_nx[i] - ONE);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]      <= '0;
                cur_div_q[i]  <= RST_DIV;
                pend_div_q[i] <= RST_DIV;
            end
            pending_q <= '0;
            clk_div_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]      <= cnt_nx[i];
                cur_div_q[i]  <= cur_div_nx[i];
                pend_div_q[i] <= pend_div_nx[i];
            end
            pending_q <= pending_nx;
            clk_div_q <= clk_div_nx;
            tick_q    <= tick_nx;
        end
    end

    assign cfg.clk_div = clk_div_q;
    assign cfg.tick    = tick_q;
    assign cfg.pending = pending_q;
endmodule

// File: tb/tb_multi_clk_divider.sv
// Randomized bench for multi_clk_divider against a period-position reference model,
// with directed sequences for odd divide, mid-period change, bypass, resets and enable drops.
module tb_multi_clk_divider;
    localparam int CH   = 3;
    localparam int CW   = 8;
    localparam int RD   = 2;
    localparam int CH_W = 2;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    multi_clk_divider_if #(.CHANNELS(CH), .CNT_W(CW)) cfg ();

    multi_clk_divider #(.CHANNELS(CH), .CNT_W(CW), .RESET_DIV(RD)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .cfg    (cfg.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each channel is described by its divisor and how far it is into the period.
    int m_pos  [CH];
    int m_n    [CH];
    int m_pn   [CH];
    bit m_pend [CH];

    logic [9:0] pat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [CH-1:0] e, input bit w,
                              input int c, input int v);
        int wv;
        bit hit;
        bit bnd;
        for (int i = 0; i < CH; i++) begin
            if (!r) begin
                m_pos[i] = 0; m_n[i] = RD; m_pn[i] = RD; m_pend[i] = 0;
            end else begin
                wv  = (v < 2) ? 2 : v;
                hit = w && (c == i);
                bnd = !e[i] || (m_pos[i] == m_n[i] - 1);
                if (bnd) begin
                    if (hit) m_n[i] = wv;
                    else if (m_pend[i]) m_n[i] = m_pn[i];
                    m_pend[i] = 0;
                    m_pos[i]  = 0;
                end else begin
                    m_pos[i]++;
                    if (hit) begin
                        m_pn[i]   = wv;
                        m_pend[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input logic [CH-1:0] e, input bit w,
                        input int c, input int v);
        @(negedge clk_in);
        rst_n       = r;
        cfg.en      = e;
        cfg.div_wr  = w;
        cfg.div_ch  = CH_W'(c);
        cfg.div_val = CW'(v);
        @(posedge clk_in);
        model_edge(r, e, w, c, v);
        #1;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("clk_div[%0d]", i), 32'(cfg.clk_div[i]), 32'(m_pos[i] >= m_n[i] / 2));
            chk($sformatf("tick[%0d]", i),    32'(cfg.tick[i]),    32'(m_pos[i] == m_n[i] - 1));
            chk($sformatf("pending[%0d]", i), 32'(cfg.pending[i]), 32'(m_pend[i]));
        end
        pat = {pat[8:0], cfg.clk_div[0]};
    endtask

    task automatic idle(input logic [CH-1:0] e, input int n);
        for (int k = 0; k < n; k++) step(1, e, 0, 0, 0);
    endtask

    initial begin
        logic [CH-1:0] e;
        int c, v, guard;
        cfg.en = '0; cfg.div_wr = 0; cfg.div_ch = '0; cfg.div_val = '0;
        pat = '0;

        // Reset, then default divide-by-2 on all channels
        step(0, '0, 0, 0, 0);
        step(0, '1, 0, 0, 0);
        chk("reset_clk_div", 32'(cfg.clk_div), 32'd0);
        chk("reset_pending", 32'(cfg.pending), 32'd0);
        idle('1, 6);

        // Odd divide: N=5 written to disabled ch0, then enabled
        step(1, 3'b110, 1, 0, 5);
        for (int k = 0; k < 9; k++) step(1, 3'b111, 0, 0, 0);
        chk("odd5_pattern", 32'(pat), 32'(10'b0011100111));

        // Mid-period change on ch0: N=4, write 6 at pos 1, then 8 at pos 2
        step(1, 3'b110, 1, 0, 4);
        guard = 0;
        do begin step(1, 3'b111, 0, 0, 0); guard++; end while (m_pos[0] != 1 && guard < 20);
        chk("midchg_reach", 32'(guard < 20), 32'd1);
        step(1, 3'b111, 1, 0, 6);
        step(1, 3'b111, 1, 0, 8);
        chk("midchg_pending", 32'(cfg.pending[0]), 32'd1);
        idle('1, 20);
        chk("midchg_n", 32'(m_n[0]), 32'd8);

        // Write coincident with ch1 boundary: bypass, pending never asserts
        step(1, 3'b111, 1, 1, 6);
        idle('1, 8);
        guard = 0;
        while (m_pos[1] != m_n[1] - 1 && guard < 20) begin step(1, 3'b111, 0, 0, 0); guard++; end
        chk("coinc_reach", 32'(guard < 20), 32'd1);
        step(1, 3'b111, 1, 1, 3);
        chk("coinc_pending", 32'(cfg.pending[1]), 32'd0);
        idle('1, 7);

        // Edge writes: value 0 clamps to 2, channel 3 is ignored
        step(1, 3'b111, 1, 2, 0);
        idle('1, 6);
        step(1, 3'b111, 1, 3, 9);
        chk("badch_pending", 32'(cfg.pending), 32'd0);
        idle('1, 6);

        // Reset during N=7 run with a pending write
        step(1, 3'b011, 1, 2, 7);
        idle('1, 10);
        step(1, 3'b111, 1, 2, 11);
        step(1, 3'b111, 0, 0, 0);
        step(0, 3'b111, 0, 0, 0);
        chk("rst_mid_clk", 32'(cfg.clk_div), 32'd0);
        chk("rst_mid_pend", 32'(cfg.pending), 32'd0);
        idle('1, 6);

        // Enable drop on ch0 during its high phase
        step(1, 3'b110, 1, 0, 6);
        guard = 0;
        do begin step(1, 3'b111, 0, 0, 0); guard++; end while (m_pos[0] != 4 && guard < 20);
        step(1, 3'b110, 0, 0, 0);
        chk("endrop_low", 32'(cfg.clk_div[0]), 32'd0);
        idle('1, 14);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) e[i] = ($urandom_range(0, 19) != 0);
            c = $urandom_range(0, 3);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            step($urandom_range(0, 149) != 0, e, $urandom_range(0, 7) == 0, c, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- Multi-channel, runtime-programmable clock-enable and divided-clock generator.
- Each channel divides clk_in by an integer N (2..2^CNT_W-1), even or odd.
- Each channel provides a registered divided-clock level and a one-cycle period tick.
- Divisor changes take effect only at period boundaries, so no runt pulses. Feeds timers, UART baud and slow-peripheral logic in the same clock domain.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..16).
- CNT_W, 16, counter/divisor width; max divisor 2^CNT_W-1.
- RESET_DIV, 2, divisor loaded into every channel at reset (2..2^CNT_W-1).

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  CHANNELS  per-channel run enable.
- div_wr  input  1  divisor write strobe, one cycle.
- div_ch  input  CH_W  target channel of write; CH_W = max(1, clog2(CHANNELS)).
- div_val  input  CNT_W  new divisor N.
- clk_div  output  CHANNELS  registered divided-clock level per channel.
- tick  output  CHANNELS  registered one-cycle pulse, last cycle of each period.
- pending  output  CHANNELS  1 = written divisor not yet applied.

Behaviour:
- Reset: clk_in edge with rst_n=0 sets, per channel:
  - cnt=0, cur_div=RESET_DIV, pend_div=RESET_DIV.
  - clk_div=0, tick=0, pending=0.
  - Reset wins over every other input, including mid-period and mid-pending.
- Counter, per channel, enabled: cnt_next = (cnt==cur_div-1) ? 0 : cnt+1.
- Duty: clk_div <= (cnt_next >= cur_div>>1).
  - Low for floor(N/2) cycles, then high for ceil(N/2) cycles.
  - Period is exactly N clk_in cycles.
- Tick: tick <= (cnt_next == cur_div-1).
  - High for exactly one cycle per period, coincident with the last high cycle of clk_div.
- Disabled (en[i]=0 at edge): cnt<=0, clk_div<=0, tick<=0.
  - On re-enable, the first period starts fresh: clk_div low for floor(N/2) cycles.
- Divisor write (div_wr=1):
  - div_val<2 is clamped to 2.
  - div_ch >= CHANNELS: write ignored, no state change.
  - Otherwise pend_div[div_ch] <= value and pending[div_ch] <= 1.
  - A write while pending overwrites pend_div; last write wins.
- Apply point (boundary), per channel: an enabled edge where cnt==cur_div-1 (counter wraps), or any edge where en=0.
  - At a boundary with pending=1: cur_div <= pend_div, pending <= 0.
  - cnt_next=0, so the new period uses the new N from its first cycle.
  - clk_div/tick for the cycle after the boundary are computed with the new divisor.
- Write coincident with a boundary on the same channel: written (clamped) value bypasses to cur_div at this boundary; pending stays 0.
- Writes to one channel never disturb other channels' cnt/clk_div/tick.
- Arithmetic: all compares are CNT_W-bit unsigned. cur_div-1 never underflows, since cur_div>=2 always.
- No combinational path from any input to any output. All outputs are registers.

Test Plan:
- Reset default: RESET_DIV=2, en=all-1 after reset -> clk_div toggles every cycle (0,1,0,1); tick high every other cycle; pending=0.
- Odd divide: write N=5 to ch0 while disabled, then enable -> clk_div pattern 0,0,1,1,1 repeating; tick once per 5 cycles on the 5th; ch1 unaffected.
- Mid-period change:
  - Setup: ch0 running N=4; write N=6 at cnt=1, then write N=8 at cnt=2.
  - Expect pending=1 until the wrap.
  - Then 8-cycle periods (4 low/4 high) with no short pulse; pending=0 after the wrap.
- Coincident write/boundary: write N=3 on the exact cycle ch1 cnt==cur_div-1 -> next period is 3 cycles; pending never asserts.
- Edge writes:
  - div_val=0 -> applied N=2.
  - div_ch=CHANNELS (CHANNELS=2, CH_W=1 cannot encode 2, so use CHANNELS=3 build, div_ch=3) -> no channel changes, no pending.
- Reset mid-operation: assert rst_n=0 for one edge during N=7 run with pending=1 -> next cycle cnt=0, clk_div=0, tick=0, pending=0, divisor back to RESET_DIV.
- Enable drop: deassert en[0] mid-high-phase -> clk_div[0]=0 next cycle; re-enable restarts a full low phase of floor(N/2) cycles.
